// File: rtl/distance_loader.sv
// distance_loader: turns a row-major host distance stream into broadcast table writes,
// generating {row,col} addresses and flagging frames whose length does not match CITY_NUM^2.
module distance_loader #(
  parameter int CITY_NUM     = 100,
  parameter int CITY_NUM_LOG = 7,
  parameter int DIST_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic                      hold,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DIST_W-1:0]         s_data,
  input  logic                      s_last,
  output logic                      busy,
  output logic                      load_done,
  output logic                      load_error,
  output logic                      distance_write,
  output logic [2*CITY_NUM_LOG-1:0] distance_w_addr,
  output logic [DIST_W-1:0]         distance_w_data
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [CITY_NUM_LOG-1:0] MAX = CITY_NUM_LOG'(CITY_NUM - 1);
  state_t state;
  logic [CITY_NUM_LOG-1:0] row, col;
  logic acc, last_addr;
  assign s_ready   = (state == LOAD) & ~hold & ~load_start;
  assign busy      = state == LOAD;
  assign acc       = s_valid & s_ready;
  assign last_addr = (row == MAX) & (col == MAX);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      row             <= '0;
      col             <= '0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
      distance_write  <= 1'b0;
      distance_w_addr <= '0;
      distance_w_data <= '0;
    end else begin
      distance_write <= acc;
      load_done      <= 1'b0;
      if (acc) begin
        distance_w_addr <= {row, col};
        distance_w_data <= s_data;
      end
      if (load_start) begin
        state      <= LOAD;
        row        <= '0;
        col        <= '0;
        load_error <= 1'b0;
      end else if (state == LOAD && acc) begin
        // the final beat leaves the counter parked so it never passes the last cell
        if (s_last | last_addr) begin
          state     <= DONE;
          load_done <= s_last & last_addr;
          if (s_last ^ last_addr) load_error <= 1'b1;
        end else begin
          col <= (col == MAX) ? '0 : col + 1'b1;
          row <= (col == MAX) ? row + 1'b1 : row;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
